// File: rtl/sad_best_match.sv
// Search controller around the SAD datapath: sweeps NUM_CAND candidate windows,
// keeps the smallest SAD and its index, and guards every run with a watchdog.
module sad_best_match #(
  parameter int NUM_CAND  = 16,
  parameter int IDX_WIDTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 SAD_Go,
  input  logic                 SAD_Done,
  input  logic [31:0]          SAD_Out,
  output logic [IDX_WIDTH-1:0] Cand_Idx,
  output logic [IDX_WIDTH-1:0] Best_Idx,
  output logic [31:0]          Best_SAD,
  output logic                 Done,
  output logic                 Timeout_Err,
  output logic [2:0]           fsm_state
);

  // Handshake: SAD_Go is a one-cycle pulse, raised only while in ISSUE; SAD_Out is
  // taken only in the cycle SAD_Done is high during WAIT; Done is a one-cycle pulse
  // and Best_* are valid from that cycle until the next Done or Rst.

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_NEXT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t                state;
  logic [31:0]           run_min;
  logic [IDX_WIDTH-1:0]  run_idx;
  logic [31:0]           cur_sad;
  logic [WDOG_W-1:0]     wdog;

  assign fsm_state = state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      Busy        <= 1'b0;
      SAD_Go      <= 1'b0;
      Cand_Idx    <= '0;
      Best_Idx    <= '0;
      Best_SAD    <= '0;
      Done        <= 1'b0;
      Timeout_Err <= 1'b0;
      run_min     <= '1;
      run_idx     <= '0;
      cur_sad     <= '0;
      wdog        <= '0;
    end else begin
      SAD_Go <= 1'b0;
      Done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            Cand_Idx    <= '0;
            run_min     <= '1;
            run_idx     <= '0;
            Timeout_Err <= 1'b0;
            SAD_Go      <= 1'b1;
            Busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last watchdog cycle is still accepted.
          if (SAD_Done) begin
            cur_sad <= SAD_Out;
            state   <= S_COMPARE;
          end else if (wdog == WDOG_LAST) begin
            Timeout_Err <= 1'b1;
            Busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        S_COMPARE: begin
          // Strict compare: ties keep the earlier candidate.
          if (cur_sad < run_min) begin
            run_min <= cur_sad;
            run_idx <= Cand_Idx;
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (Cand_Idx == LAST_IDX) begin
            Best_SAD <= run_min;
            Best_Idx <= run_idx;
            Done     <= 1'b1;
            state    <= S_FINISH;
          end else begin
            Cand_Idx <= Cand_Idx + IDX_WIDTH'(1);
            SAD_Go   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_FINISH: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
